// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-I accumulator core: widths, opcodes,
// datapath mux encodings and the ALU operation select.
package bip_pkg;

  localparam int BIP_DATA_W   = 16;
  localparam int BIP_ADDR_W   = 11;
  localparam int BIP_DM_DEPTH = 2048;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    SEL_A_DM  = 2'd0,
    SEL_A_IMM = 2'd1,
    SEL_A_ALU = 2'd2
  } sel_a_e;

  typedef enum logic {
    SEL_B_DM  = 1'b0,
    SEL_B_IMM = 1'b1
  } sel_b_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/bip_data_mem.sv
// Data memory: combinational read, rising-edge write, whole array
// cleared synchronously while reset is high (reset beats a write).
module bip_data_mem
  import bip_pkg::*;
#(
  parameter int DATA_W = BIP_DATA_W,
  parameter int ADDR_W = BIP_ADDR_W,
  parameter int DEPTH  = BIP_DM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Array storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bip_cpu_core.sv
// Single-cycle BIP-I core: decode, PC, accumulator, add/sub ALU and the
// data memory instance. One instruction retires per clock.
module bip_cpu_core
  import bip_pkg::*;
#(
  parameter int DATA_W   = BIP_DATA_W,
  parameter int ADDR_W   = BIP_ADDR_W,
  parameter int DM_DEPTH = BIP_DM_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] INSTRUCTION,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] ACC,
  output logic              WR_ACC,
  output logic              WR_RAM,
  output logic              RD_RAM
);

  logic [4:0]        opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] dm_rdata_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              halt_s;
  logic              wr_acc_s;
  logic              wr_ram_s;
  logic              rd_ram_s;
  sel_a_e            sel_a_s;
  sel_b_e            sel_b_s;
  alu_op_e           op_s;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  assign opcode_s  = INSTRUCTION[DATA_W-1:ADDR_W];
  assign operand_s = INSTRUCTION[ADDR_W-1:0];
  assign imm_s     = {{(DATA_W-ADDR_W){operand_s[ADDR_W-1]}}, operand_s};

  // Instruction decode; opcodes 01000..11111 fall to the NOP defaults.
  always_comb begin
    halt_s   = 1'b0;
    wr_acc_s = 1'b0;
    wr_ram_s = 1'b0;
    rd_ram_s = 1'b0;
    sel_a_s  = SEL_A_DM;
    sel_b_s  = SEL_B_DM;
    op_s     = OP_ADD;
    case (opcode_s)
      OPC_HLT:  halt_s = 1'b1;
      OPC_STO:  wr_ram_s = 1'b1;
      OPC_LD: begin
        rd_ram_s = 1'b1;
        wr_acc_s = 1'b1;
        sel_a_s  = SEL_A_DM;
      end
      OPC_LDI: begin
        wr_acc_s = 1'b1;
        sel_a_s  = SEL_A_IMM;
      end
      OPC_ADD: begin
        rd_ram_s = 1'b1;
        wr_acc_s = 1'b1;
        sel_a_s  = SEL_A_ALU;
      end
      OPC_ADDI: begin
        wr_acc_s = 1'b1;
        sel_a_s  = SEL_A_ALU;
        sel_b_s  = SEL_B_IMM;
      end
      OPC_SUB: begin
        rd_ram_s = 1'b1;
        wr_acc_s = 1'b1;
        sel_a_s  = SEL_A_ALU;
        op_s     = OP_SUB;
      end
      OPC_SUBI: begin
        wr_acc_s = 1'b1;
        sel_a_s  = SEL_A_ALU;
        sel_b_s  = SEL_B_IMM;
        op_s     = OP_SUB;
      end
      default: ;
    endcase
  end

  // ALU operand mux, add/subtract and accumulator/PC next state.
  always_comb begin
    alu_b_s   = (sel_b_s == SEL_B_IMM) ? imm_s : dm_rdata_s;
    alu_res_s = (op_s == OP_SUB) ? (acc_q - alu_b_s) : (acc_q + alu_b_s);
    acc_d     = acc_q;
    if (wr_acc_s) begin
      case (sel_a_s)
        SEL_A_DM:  acc_d = dm_rdata_s;
        SEL_A_IMM: acc_d = imm_s;
        SEL_A_ALU: acc_d = alu_res_s;
        default:   acc_d = acc_q;
      endcase
    end else begin
      acc_d = acc_q;
    end
    if (halt_s) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Architectural state; the PC wraps naturally at its width.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q  <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
    end
  end

  assign PC     = pc_q;
  assign ACC    = acc_q;
  assign WR_ACC = wr_acc_s & ~RESET;
  assign WR_RAM = wr_ram_s & ~RESET;
  assign RD_RAM = rd_ram_s & ~RESET;

  bip_data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DM_DEPTH)
  ) u_dmem (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (WR_RAM),
    .addr_i  (operand_s),
    .wdata_i (acc_q),
    .rdata_o (dm_rdata_s)
  );

endmodule

// File: tb/tb_bip_cpu_core.sv
// Directed bench for bip_cpu_core: hand-computed ACC/PC/strobe values
// checked with immediate assertions after each instruction.
module tb_bip_cpu_core;

  logic        CLK;
  logic        RESET;
  logic [15:0] INSTRUCTION;
  logic [10:0] PC;
  logic [15:0] ACC;
  logic        WR_ACC;
  logic        WR_RAM;
  logic        RD_RAM;

  int n_assert = 0;
  int n_fail   = 0;
  logic [10:0] exp_pc;

  bip_cpu_core dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC),
    .ACC         (ACC),
    .WR_ACC      (WR_ACC),
    .WR_RAM      (WR_RAM),
    .RD_RAM      (RD_RAM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, check strobes mid-cycle, then ACC/PC after the edge.
  task automatic exec(input string tag, input logic [15:0] ins, input logic [15:0] acc_exp,
                      input logic wacc, input logic wram, input logic rram);
    INSTRUCTION = ins;
    #1;
    chk({tag, ".WR_ACC"}, {15'd0, WR_ACC}, {15'd0, wacc});
    chk({tag, ".WR_RAM"}, {15'd0, WR_RAM}, {15'd0, wram});
    chk({tag, ".RD_RAM"}, {15'd0, RD_RAM}, {15'd0, rram});
    if (ins[15:11] != 5'd0) exp_pc = exp_pc + 11'd1;
    else                    exp_pc = exp_pc;
    @(posedge CLK);
    #1;
    chk({tag, ".ACC"}, ACC, acc_exp);
    chk({tag, ".PC"}, {5'd0, PC}, {5'd0, exp_pc});
  endtask

  initial begin
    RESET       = 1'b1;
    INSTRUCTION = 16'h1805;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.PC", {5'd0, PC}, 16'h0000);
    chk("rst.ACC", ACC, 16'h0000);
    chk("rst.WR_ACC", {15'd0, WR_ACC}, 16'h0000);
    chk("rst.WR_RAM", {15'd0, WR_RAM}, 16'h0000);
    chk("rst.RD_RAM", {15'd0, RD_RAM}, 16'h0000);
    RESET  = 1'b0;
    exp_pc = 11'd0;

    exec("ldi5",    16'h1805, 16'h0005, 1'b1, 1'b0, 1'b0);
    exec("addi3",   16'h2803, 16'h0008, 1'b1, 1'b0, 1'b0);
    exec("subi10",  16'h380A, 16'hFFFE, 1'b1, 1'b0, 1'b0);

    exec("ldi8",    16'h1808, 16'h0008, 1'b1, 1'b0, 1'b0);
    exec("sto10",   16'h080A, 16'h0008, 1'b0, 1'b1, 1'b0);
    exec("ldi0",    16'h1800, 16'h0000, 1'b1, 1'b0, 1'b0);
    exec("ld10",    16'h100A, 16'h0008, 1'b1, 1'b0, 1'b1);

    exec("ldi20",   16'h1814, 16'h0014, 1'b1, 1'b0, 1'b0);
    exec("add10",   16'h200A, 16'h001C, 1'b1, 1'b0, 1'b1);
    exec("sub10",   16'h300A, 16'h0014, 1'b1, 1'b0, 1'b1);

    exec("ldi7ff",  16'h1FFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    exec("addi1",   16'h2801, 16'h0000, 1'b1, 1'b0, 1'b0);
    exec("ldi3ff",  16'h1BFF, 16'h03FF, 1'b1, 1'b0, 1'b0);

    // Store immediately followed by a read of the same address.
    exec("ldi123",  16'h1923, 16'h0123, 1'b1, 1'b0, 1'b0);
    exec("sto5",    16'h0805, 16'h0123, 1'b0, 1'b1, 1'b0);
    exec("add5",    16'h2005, 16'h0246, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      exec("hlt",   16'h0000, 16'h0246, 1'b0, 1'b0, 1'b0);
    end
    exec("nop08",   16'h4000, 16'h0246, 1'b0, 1'b0, 1'b0);

    // Reset mid-program with a pending STO: no write, memory cleared.
    RESET       = 1'b1;
    INSTRUCTION = 16'h080A;
    #1;
    chk("midrst.WR_RAM", {15'd0, WR_RAM}, 16'h0000);
    @(posedge CLK);
    #1;
    chk("midrst.PC", {5'd0, PC}, 16'h0000);
    chk("midrst.ACC", ACC, 16'h0000);
    RESET  = 1'b0;
    exp_pc = 11'd0;
    exec("ld10clr", 16'h100A, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Walk to the top of the PC range and wrap.
    INSTRUCTION = 16'hF800;
    for (int i = 0; i < 2046; i++) begin
      @(posedge CLK);
    end
    #1;
    exp_pc = 11'd2047;
    chk("pc2047", {5'd0, PC}, 16'h07FF);
    exec("nopwrap", 16'hF800, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("wrap.PC0", {5'd0, PC}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
